hard_decision_unit: RTL and testbench

// Output end of the min-sum decoder: consumes the final check-to-variable edge messages of the

---
 rtl/ldpc_pkg.sv | 24 ++
 rtl/sat_add.sv | 31 +++
 rtl/hard_decision_unit.sv | 146 ++++++++++++++
 tb/tb_hard_decision_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared definitions for the min-sum decoder output stage.
package ldpc_pkg;

    localparam int unsigned IDX_W      = 8;
    localparam int unsigned MSG_W      = 8;
    localparam int unsigned ACC_W_DEF  = 12;
    localparam int unsigned E_DEF      = 147;
    localparam int unsigned EDGE_CNT_W = $clog2(E_DEF);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACCUM,
        DECIDE,
        PARITY,
        REPORT
    } state_t;

    // Graph indices at or above the node count mark padding edges.
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int unsigned limit);
        return 32'(idx) < limit;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed accumulator plus message adder, clamped to a symmetric range.
module sat_add
    import ldpc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned B_W   = MSG_W
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] sum
);

    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [ACC_W:0] MIN_V = -MAX_V;

    logic signed [ACC_W:0] wide;

    // One guard bit is enough: a is already within the clamp range and B_W <= ACC_W.
    assign wide = (ACC_W+1)'(a) + (ACC_W+1)'(b);

    // Clamp symmetrically so the most negative code never appears.
    always_comb begin
        sum = wide[ACC_W-1:0];
        if (wide > MAX_V) begin
            sum = MAX_V[ACC_W-1:0];
        end else if (wide < MIN_V) begin
            sum = MIN_V[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/hard_decision_unit.sv
// Final stage of the min-sum decoder: serial posterior accumulation over all edges, hard
// decision per variable, then a second serial sweep evaluating every parity check.
module hard_decision_unit
    import ldpc_pkg::*;
#(
    parameter int unsigned N_V   = 44,
    parameter int unsigned N_C   = 12,
    parameter int unsigned E     = E_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic        [IDX_W-1:0]       tanner_g  [E][2],
    input  logic signed [MSG_W-1:0]       llr       [N_V],
    input  logic signed [MSG_W-1:0]       proc_elem [E],
    output logic                          busy,
    output logic                          done,
    output logic        [N_V-1:0]         hard_bits,
    output logic                          syndrome_ok,
    output logic        [$clog2(N_C+1)-1:0] unsat_cnt
);

    localparam int unsigned CNT_W = $clog2(E);
    localparam int unsigned VW    = $clog2(N_V);
    localparam int unsigned CW    = $clog2(N_C);
    localparam int unsigned UW    = $clog2(N_C + 1);

    state_t state_q, state_d;

    logic        [CNT_W-1:0] e_q;
    logic signed [ACC_W-1:0] acc_q [N_V];
    logic signed [MSG_W-1:0] pe_q  [E];
    logic        [N_V-1:0]   hb_q;
    logic        [N_C-1:0]   par_q;

    logic [IDX_W-1:0]        v_raw, c_raw;
    logic                    edge_ok;
    logic [VW-1:0]           v_sel;
    logic [CW-1:0]           c_sel;
    logic                    last_edge;
    logic signed [ACC_W-1:0] acc_sum;
    logic [UW-1:0]           par_cnt;

    // Single shared read port: the edge counter selects one graph entry per cycle.
    assign v_raw     = tanner_g[e_q][0];
    assign c_raw     = tanner_g[e_q][1];
    assign edge_ok   = idx_in_range(v_raw, N_V) && idx_in_range(c_raw, N_C);
    assign v_sel     = edge_ok ? v_raw[VW-1:0] : '0;
    assign c_sel     = edge_ok ? c_raw[CW-1:0] : '0;
    assign last_edge = (e_q == CNT_W'(E - 1));
    assign busy      = (state_q != IDLE);

    sat_add #(
        .ACC_W (ACC_W),
        .B_W   (MSG_W)
    ) u_sat_add (
        .a   (acc_q[v_sel]),
        .b   (pe_q[e_q]),
        .sum (acc_sum)
    );

    // Next-state: fixed sequence, sweeps end on the last edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = ACCUM;
            ACCUM:   if (last_edge) state_d = DECIDE;
            DECIDE:  state_d = PARITY;
            PARITY:  if (last_edge) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Edge counter: runs during both sweeps, parked at zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q <= '0;
        end else if ((state_q == ACCUM || state_q == PARITY) && !last_edge) begin
            e_q <= e_q + CNT_W'(1);
        end else begin
            e_q <= '0;
        end
    end

    // Datapath: snapshot, posterior accumulation, decision and parity update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < N_V; v++) acc_q[v] <= '0;
            for (int e = 0; e < E; e++)   pe_q[e]  <= '0;
            hb_q  <= '0;
            par_q <= '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    for (int v = 0; v < N_V; v++) acc_q[v] <= ACC_W'(llr[v]);
                    for (int e = 0; e < E; e++)   pe_q[e]  <= proc_elem[e];
                    par_q <= '0;
                end
                ACCUM: begin
                    if (edge_ok) acc_q[v_sel] <= acc_sum;
                end
                DECIDE: begin
                    // Sign bit: zero posterior decides 0.
                    for (int v = 0; v < N_V; v++) hb_q[v] <= acc_q[v][ACC_W-1];
                end
                PARITY: begin
                    if (edge_ok) par_q[c_sel] <= par_q[c_sel] ^ hb_q[v_sel];
                end
                default: ;
            endcase
        end
    end

    // Count of unsatisfied checks.
    always_comb begin
        par_cnt = '0;
        for (int c = 0; c < N_C; c++) par_cnt = par_cnt + UW'(par_q[c]);
    end

    // Reported outputs hold until the next REPORT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done        <= 1'b0;
            hard_bits   <= '0;
            syndrome_ok <= 1'b0;
            unsat_cnt   <= '0;
        end else begin
            done <= (state_q == REPORT);
            if (state_q == REPORT) begin
                hard_bits   <= hb_q;
                syndrome_ok <= (par_q == '0);
                unsat_cnt   <= par_cnt;
            end
        end
    end

endmodule

// File: tb/tb_hard_decision_unit.sv
// Directed, table-driven bench for hard_decision_unit.
module tb_hard_decision_unit;

    localparam int N_V = 44;
    localparam int N_C = 12;
    localparam int E   = 147;
    localparam int LAT = 2 * E + 3;
    localparam int NV  = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic        [7:0] tanner_g  [E][2];
    logic signed [7:0] llr       [N_V];
    logic signed [7:0] proc_elem [E];
    logic              busy, done, syndrome_ok;
    logic [N_V-1:0]    hard_bits;
    logic [3:0]        unsat_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hard_decision_unit #(
        .N_V   (N_V),
        .N_C   (N_C),
        .E     (E),
        .ACC_W (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .tanner_g    (tanner_g),
        .llr         (llr),
        .proc_elem   (proc_elem),
        .busy        (busy),
        .done        (done),
        .hard_bits   (hard_bits),
        .syndrome_ok (syndrome_ok),
        .unsat_cnt   (unsat_cnt)
    );

    // g=0: regular graph v=e%44, c=(e+e/44)%12 with padding edges 144..146;
    // g=1: every edge on variable sv, check e%12.
    // Edges on sv (in order): first n1 get p1, next n2 get p2, the next one gets p3.
    typedef struct {
        int          g;
        int          sv;
        int          sv_llr;
        int          n1;
        int          p1;
        int          n2;
        int          p2;
        int          p3;
        int          pad;
        logic [43:0] hb;
        logic        ok;
        int          cnt;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setup(input vec_t v);
        int k;
        int vi;
        int ci;
        int pe;
        k = 0;
        for (int i = 0; i < N_V; i++) llr[i] = 8'(10);
        llr[v.sv] = 8'(v.sv_llr);
        for (int e = 0; e < E; e++) begin
            if (v.g == 0) begin
                if (e < 144) begin
                    vi = e % 44;
                    ci = (e + e / 44) % 12;
                end else if (e == 144) begin
                    vi = 255; ci = 0;
                end else if (e == 145) begin
                    vi = 0; ci = 255;
                end else begin
                    vi = 255; ci = 255;
                end
            end else begin
                vi = v.sv;
                ci = e % 12;
            end
            tanner_g[e][0] = 8'(vi);
            tanner_g[e][1] = 8'(ci);
            pe = 0;
            if (vi == v.sv && ci < N_C) begin
                if (k < v.n1)              pe = v.p1;
                else if (k < v.n1 + v.n2)  pe = v.p2;
                else if (k == v.n1 + v.n2) pe = v.p3;
                k++;
            end else if (vi >= N_V || ci >= N_C) begin
                pe = v.pad;
            end
            proc_elem[e] = 8'(pe);
        end
    endtask

    // Caller sits just after a clock edge; start is sampled at the next edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n, output bit busy_bad);
        n = 0;
        busy_bad = 1'b0;
        while (n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (!busy) busy_bad = 1'b1;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, " hard_bits"}, 64'(hard_bits), 64'(v.hb));
        chk({tag, " syndrome_ok"}, 64'(syndrome_ok), 64'(v.ok));
        chk({tag, " unsat_cnt"}, 64'(unsat_cnt), 64'(v.cnt));
    endtask

    task automatic run_vec(input int i);
        int  n;
        bit  bb;
        string tag;
        tag = $sformatf("v%0d", i);
        setup(vecs[i]);
        pulse_start();
        wait_done(LAT + 20, n, bb);
        chk({tag, " latency"}, 64'(n), 64'(LAT));
        chk({tag, " busy during run"}, 64'(bb), 64'(0));
        chk({tag, " busy at done"}, 64'(busy), 64'(0));
        check_result(tag, vecs[i]);
        @(posedge clk);
        #1 chk({tag, " done is a pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int  n;
        bit  bb;
        bit  got;
        bit  saw;

        //            g  sv  llr   n1   p1   n2  p2  p3  pad   hb            ok  cnt
        vecs[0]  = '{0, 0,  10,    0,   0,   0,  0,  0,    0, 44'h0,        1'b1, 0};
        vecs[1]  = '{0, 0,  -5,    0,   0,   0,  0,  0,    0, 44'h1,        1'b0, 4};
        vecs[2]  = '{0, 3,   2,    1,  -2,   0,  0,  0,    0, 44'h0,        1'b1, 0};
        vecs[3]  = '{0, 3,   2,    1,  -3,   0,  0,  0,    0, 44'h8,        1'b0, 4};
        vecs[4]  = '{0, 0,  10,    0,   0,   0,  0,  0, -128, 44'h0,        1'b1, 0};
        vecs[5]  = '{0, 0,  -5,    0,   0,   0,  0,  0, -128, 44'h1,        1'b0, 4};
        vecs[6]  = '{0, 20, -1,    0,   0,   0,  0,  0,    0, 44'h100000,   1'b0, 3};
        vecs[7]  = '{1, 5, -128, 147, -128,  0,  0,  0,    0, 44'h20,       1'b0, 3};
        vecs[8]  = '{1, 5,  127, 147,  127,  0,  0,  0,    0, 44'h0,        1'b1, 0};
        vecs[9]  = '{1, 5, -128, 100, -128, 16, 127, 15,   0, 44'h0,        1'b1, 0};
        vecs[10] = '{1, 5, -128, 100, -128, 16, 127, 14,   0, 44'h20,       1'b0, 3};
        vecs[11] = '{0, 43, -1,    0,   0,   0,  0,  0,    0, 44'h80000000000, 1'b0, 3};

        setup(vecs[0]);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset hard_bits", 64'(hard_bits), 64'(0));
        chk("reset syndrome_ok", 64'(syndrome_ok), 64'(0));
        chk("reset unsat_cnt", 64'(unsat_cnt), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Start while busy is ignored; start on the done cycle launches a second run.
        setup(vecs[1]);
        pulse_start();
        n = 0;
        got = 1'b0;
        while (n < LAT + 20 && !got) begin
            start = (n == 10);
            @(posedge clk);
            #1;
            n++;
            got = done;
        end
        start = 1'b0;
        chk("busy restart latency", 64'(n), 64'(LAT));
        check_result("busy restart", vecs[1]);
        setup(vecs[3]);
        pulse_start();
        wait_done(LAT + 20, n, bb);
        chk("done-cycle restart latency", 64'(n), 64'(LAT));
        check_result("done-cycle restart", vecs[3]);

        // Outputs hold after the report regardless of new inputs.
        setup(vecs[0]);
        repeat (5) @(posedge clk);
        #1;
        chk("hold hard_bits", 64'(hard_bits), 64'(vecs[3].hb));
        chk("hold unsat_cnt", 64'(unsat_cnt), 64'(vecs[3].cnt));
        chk("hold done", 64'(done), 64'(0));

        // Reset during ACCUM aborts the run and clears outputs immediately.
        setup(vecs[1]);
        pulse_start();
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort hard_bits", 64'(hard_bits), 64'(0));
        chk("abort syndrome_ok", 64'(syndrome_ok), 64'(0));
        chk("abort unsat_cnt", 64'(unsat_cnt), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < LAT + 10; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw = 1'b1;
        end
        chk("abort no done or busy", 64'(saw), 64'(0));

        run_vec(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
